// File: rtl/integral_frame_sched_pkg.sv
// integral_frame_sched_pkg: shared state encoding, default geometry and counter-width helper
package integral_frame_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, KICK, COMPUTE, READOUT} state_t;
  localparam int IMG_W_DEF   = 4;
  localparam int IMG_H_DEF   = 4;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 1024;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int PIX_CNT_W = cnt_w(IMG_W_DEF * IMG_H_DEF);
endpackage

// File: rtl/integral_frame_sched_m10k_port_mux.sv
// m10k_port_mux: selects the controller's registered port or the engine's port with zero added latency
module m10k_port_mux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              bypass,
  input  logic              r_we,
  input  logic [ADDR_W-1:0] r_waddr,
  input  logic [DATA_W-1:0] r_wdata,
  input  logic [ADDR_W-1:0] r_raddr,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_waddr,
  input  logic [DATA_W-1:0] e_wdata,
  input  logic [ADDR_W-1:0] e_raddr,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] raddr
);
  always_comb begin
    we    = bypass ? e_we    : r_we;
    waddr = bypass ? e_waddr : r_waddr;
    wdata = bypass ? e_wdata : r_wdata;
    raddr = bypass ? e_raddr : r_raddr;
  end
endmodule

// File: rtl/integral_frame_sched.sv
// integral_frame_sched: frame controller that loads a raster frame, runs the integral engine,
// and serves host read-back of the integral M10K
module integral_frame_sched
  import integral_frame_sched_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              eng_reset,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic              eng_src_we,
  input  logic [ADDR_W-1:0] eng_src_waddr,
  input  logic [DATA_W-1:0] eng_src_wdata,
  input  logic [ADDR_W-1:0] eng_src_raddr,
  input  logic              eng_int_we,
  input  logic [ADDR_W-1:0] eng_int_waddr,
  input  logic [DATA_W-1:0] eng_int_wdata,
  input  logic [ADDR_W-1:0] eng_int_raddr,
  output logic              src_we,
  output logic [ADDR_W-1:0] src_waddr,
  output logic [DATA_W-1:0] src_wdata,
  output logic [ADDR_W-1:0] src_raddr,
  output logic              int_we,
  output logic [ADDR_W-1:0] int_waddr,
  output logic [DATA_W-1:0] int_wdata,
  output logic [ADDR_W-1:0] int_raddr,
  input  logic [DATA_W-1:0] int_q,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              frame_ack,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              err_timeout
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = cnt_w(NPIX);
  localparam int WW   = cnt_w(TIMEOUT);
  state_t            state;
  logic [PW-1:0]     pix_cnt;
  logic [WW-1:0]     wd;
  logic              s_we;
  logic [ADDR_W-1:0] s_waddr;
  logic [DATA_W-1:0] s_wdata;
  logic [ADDR_W-1:0] i_raddr;
  logic              p1, p2, ack_pend, ack_en;
  logic              req, go, next_en;
  // a frame_ack is held pending until every accepted read has returned
  always_comb begin
    req     = state == READOUT && rd_req && !ack_pend;
    go      = state == READOUT && (frame_ack || ack_pend) && !req && !p1 && !p2;
    next_en = ack_pend ? ack_en : enable;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pix_ready   <= 1'b0;
      eng_reset   <= 1'b1;
      eng_start   <= 1'b0;
      s_we        <= 1'b0;
      s_waddr     <= '0;
      s_wdata     <= '0;
      i_raddr     <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      err_timeout <= 1'b0;
      pix_cnt     <= '0;
      wd          <= '0;
      p1          <= 1'b0;
      p2          <= 1'b0;
      ack_pend    <= 1'b0;
      ack_en      <= 1'b0;
    end else begin
      s_we     <= 1'b0;
      p1       <= req;
      p2       <= p1;
      rd_valid <= p2;
      if (p2) rd_data <= int_q;
      case (state)
        IDLE: if (enable) begin
          state       <= LOAD;
          pix_ready   <= 1'b1;
          pix_cnt     <= '0;
          err_timeout <= 1'b0;
          busy        <= 1'b1;
        end
        LOAD: if (pix_valid && pix_ready) begin
          s_we    <= 1'b1;
          s_waddr <= ADDR_W'(pix_cnt);
          s_wdata <= pix_data;
          pix_cnt <= pix_cnt + 1'b1;
          if (pix_cnt == PW'(NPIX - 1)) begin
            pix_ready <= 1'b0;
            eng_reset <= 1'b0;
            state     <= KICK;
          end
        end
        KICK: begin
          eng_start <= 1'b1;
          wd        <= '0;
          state     <= COMPUTE;
        end
        COMPUTE: if (eng_done) begin
          eng_reset <= 1'b1;
          eng_start <= 1'b0;
          ack_pend  <= 1'b0;
          state     <= READOUT;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          err_timeout <= 1'b1;
          eng_reset   <= 1'b1;
          eng_start   <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end else wd <= wd + 1'b1;
        READOUT: begin
          if (req) i_raddr <= rd_addr;
          if (go) begin
            frame_cnt <= frame_cnt + 1'b1;
            ack_pend  <= 1'b0;
            state     <= next_en ? LOAD : IDLE;
            pix_ready <= next_en;
            busy      <= next_en;
            pix_cnt   <= '0;
          end else if (frame_ack && !ack_pend) begin
            ack_pend <= 1'b1;
            ack_en   <= enable;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  m10k_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_src_mux (
    .bypass(state == COMPUTE),
    .r_we(s_we), .r_waddr(s_waddr), .r_wdata(s_wdata), .r_raddr('0),
    .e_we(eng_src_we), .e_waddr(eng_src_waddr), .e_wdata(eng_src_wdata), .e_raddr(eng_src_raddr),
    .we(src_we), .waddr(src_waddr), .wdata(src_wdata), .raddr(src_raddr)
  );
  m10k_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_int_mux (
    .bypass(state == COMPUTE),
    .r_we(1'b0), .r_waddr('0), .r_wdata('0), .r_raddr(i_raddr),
    .e_we(eng_int_we), .e_waddr(eng_int_waddr), .e_wdata(eng_int_wdata), .e_raddr(eng_int_raddr),
    .we(int_we), .waddr(int_waddr), .wdata(int_wdata), .raddr(int_raddr)
  );
endmodule

// File: tb/tb_integral_frame_sched.sv
// tb_integral_frame_sched: scoreboard bench for load, compute hand-off, read-back, watchdog and reset
module tb_integral_frame_sched;
  logic clk = 0, reset = 0, enable = 0;
  logic pix_valid = 0, pix_ready;
  logic [7:0] pix_data = 0;
  logic eng_reset, eng_start, eng_done = 0;
  logic eng_src_we = 0, eng_int_we = 0;
  logic [7:0] eng_src_waddr = 0, eng_src_wdata = 0, eng_src_raddr = 0;
  logic [7:0] eng_int_waddr = 0, eng_int_wdata = 0, eng_int_raddr = 0;
  logic src_we, int_we;
  logic [7:0] src_waddr, src_wdata, src_raddr, int_waddr, int_wdata, int_raddr;
  logic [7:0] int_q = 0;
  logic rd_req = 0, rd_valid, frame_ack = 0, busy, err_timeout;
  logic [7:0] rd_addr = 0, rd_data;
  logic [15:0] frame_cnt;
  logic [7:0] mem_int [256];
  typedef struct {int cyc; logic [7:0] data;} rd_t;
  rd_t rd_q[$];
  logic [15:0] src_q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, exp_addr = 0;

  integral_frame_sched #(.IMG_W(4), .IMG_H(4), .ADDR_W(8), .DATA_W(8), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
    .eng_src_we(eng_src_we), .eng_src_waddr(eng_src_waddr), .eng_src_wdata(eng_src_wdata), .eng_src_raddr(eng_src_raddr),
    .eng_int_we(eng_int_we), .eng_int_waddr(eng_int_waddr), .eng_int_wdata(eng_int_wdata), .eng_int_raddr(eng_int_raddr),
    .src_we(src_we), .src_waddr(src_waddr), .src_wdata(src_wdata), .src_raddr(src_raddr),
    .int_we(int_we), .int_waddr(int_waddr), .int_wdata(int_wdata), .int_raddr(int_raddr),
    .int_q(int_q), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .frame_ack(frame_ack), .busy(busy), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (int_we) mem_int[int_waddr] <= int_wdata;
    int_q <= mem_int[int_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && src_we) begin
      if (src_q.size() == 0) chk("src_unexpected", 1, 0);
      else chk("src_write", {src_waddr, src_wdata}, src_q.pop_front());
    end
    if (rd_valid) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        rd_t e;
        e = rd_q.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_data", rd_data, e.data);
      end
    end
  end

  task automatic send_pix(input int n, input logic [7:0] v, input bit toggle);
    int sent = 0, guard = 0;
    while (sent < n && guard < 200) begin
      pix_valid = 1;
      pix_data  = v;
      if (pix_ready) begin
        src_q.push_back({8'(exp_addr), v});
        exp_addr++;
        sent++;
      end
      @(negedge clk);
      guard++;
      if (toggle && sent < n) begin
        pix_valid = 0;
        @(negedge clk);
        guard++;
      end
    end
    pix_valid = 0;
    if (sent < n) chk("pix_stall", sent, n);
  endtask

  task automatic read(input logic [7:0] a, input bit ack);
    rd_req = 1; rd_addr = a; frame_ack = ack;
    rd_q.push_back('{cyc + 3, a + 8'd1});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_int[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_eng_reset", eng_reset, 1);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_rd_valid", rd_valid, 0);
    reset = 1;
    enable = 1;
    send_pix(5, 8'h09, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", pix_ready, 0);
    chk("mid_rst_eng_reset", eng_reset, 1);
    chk("mid_rst_src_we", src_we, 0);
    chk("mid_rst_src_waddr", src_waddr, 0);
    chk("mid_rst_src_q", src_q.size(), 0);
    src_q.delete();
    exp_addr = 0;
    reset = 1;
    send_pix(8, 8'h01, 1);
    eng_done = 1; rd_req = 1; rd_addr = 3;
    @(negedge clk);
    eng_done = 0; rd_req = 0;
    repeat (3) @(negedge clk);
    chk("load_ignore_busy", busy, 1);
    chk("load_ignore_ready", pix_ready, 1);
    chk("load_ignore_start", eng_start, 0);
    chk("load_ignore_eng_reset", eng_reset, 1);
    send_pix(8, 8'h01, 1);
    chk("kick_ready_low", pix_ready, 0);
    chk("kick_eng_reset", eng_reset, 0);
    chk("kick_eng_start", eng_start, 0);
    chk("load_count", exp_addr, 16);
    @(negedge clk);
    chk("compute_start", eng_start, 1);
    for (int i = 0; i < 16; i++) begin
      eng_int_we = 1; eng_int_waddr = 8'(i); eng_int_wdata = 8'(i + 1); eng_int_raddr = 8'(15 - i);
      #1;
      chk("int_pass", {int_we, int_waddr, int_wdata, int_raddr}, {1'b1, 8'(i), 8'(i + 1), 8'(15 - i)});
      @(negedge clk);
    end
    eng_int_we = 0;
    eng_src_raddr = 8'h05;
    #1;
    chk("src_raddr_pass", src_raddr, 8'h05);
    eng_src_raddr = 0;
    eng_done = 1;
    @(negedge clk);
    eng_done = 0;
    chk("done_eng_reset", eng_reset, 1);
    chk("done_eng_start", eng_start, 0);
    chk("done_busy", busy, 1);
    read(8'd15, 0);
    @(negedge clk);
    read(8'd0, 0);
    @(negedge clk);
    rd_req = 0;
    repeat (4) @(negedge clk);
    enable = 0;
    read(8'd7, 1);
    @(negedge clk);
    rd_req = 0; frame_ack = 0;
    repeat (6) @(negedge clk);
    chk("ack_frame_cnt", frame_cnt, 1);
    chk("ack_idle_busy", busy, 0);
    chk("rd_q_drained", rd_q.size(), 0);
    enable = 1;
    exp_addr = 0;
    send_pix(16, 8'h02, 0);
    @(negedge clk);
    chk("wd_compute_start", eng_start, 1);
    enable = 0;
    repeat (31) @(negedge clk);
    chk("wd_cycle32_err", err_timeout, 0);
    chk("wd_cycle32_start", eng_start, 1);
    @(negedge clk);
    chk("wd_err", err_timeout, 1);
    chk("wd_eng_reset", eng_reset, 1);
    chk("wd_eng_start", eng_start, 0);
    chk("wd_busy", busy, 0);
    chk("wd_frame_cnt", frame_cnt, 1);
    repeat (3) @(negedge clk);
    chk("wd_stays_idle", busy, 0);
    chk("wd_err_sticky", err_timeout, 1);
    chk("src_q_drained", src_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
